cpu_imem_arbiter: RTL

Shares the single instruction-memory port (request/ready, address, 9-bit tag carried in wdata[8:0], in-order rdata/raddr/rtag/rvalid return) between two read-only requesters. Port A is the instruction fetch unit; port B is a secondary reader such as data-side constant loads or debug reads of the ROM region. Arbitration is fixed-priority with a starvation counter. An in-order grant FIFO routes each response back to the requester that issued it.

---
 rtl/cpu_imem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cpu_imem_arbiter.sv
// Shares one read-only instruction-memory port between a fetch unit (A) and a secondary reader (B).
// Fixed priority to A, with B promoted after STARVE_LIMIT blocked cycles; an in-order grant FIFO routes responses.
module cpu_imem_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_request,
    output logic        a_ready,
    input  logic [31:0] a_address,
    input  logic [8:0]  a_tag,
    output logic [31:0] a_rdata,
    output logic [31:0] a_raddr,
    output logic [8:0]  a_rtag,
    output logic        a_rvalid,
    input  logic        b_request,
    output logic        b_ready,
    input  logic [31:0] b_address,
    input  logic [8:0]  b_tag,
    output logic [31:0] b_rdata,
    output logic [31:0] b_raddr,
    output logic [8:0]  b_rtag,
    output logic        b_rvalid,
    output logic        mem_request,
    input  logic        mem_ready,
    output logic        mem_write,
    output logic        mem_burst,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] mem_raddr,
    input  logic [8:0]  mem_rtag,
    input  logic        mem_rvalid,
    output logic        err_orphan
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [DEPTH-1:0] r_grant;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;
    logic             r_err_orphan;

    logic w_full;
    logic w_empty;
    logic w_sel_b;
    logic w_accept;
    logic w_pop;
    logic w_head_b;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_sel_b  = b_request && (!a_request || (r_starve == SW'(STARVE_LIMIT)));

    // Full is taken from the registered count only, so mem_rvalid never reaches the ready path.
    assign mem_request = (a_request || b_request) && !w_full;
    assign a_ready     = mem_ready && !w_full && !w_sel_b;
    assign b_ready     = mem_ready && !w_full && w_sel_b;
    assign w_accept    = mem_request && mem_ready;

    assign mem_write   = 1'b0;
    assign mem_burst   = 1'b0;
    assign mem_wstrb   = 4'b0;
    assign mem_address = w_sel_b ? b_address : a_address;
    assign mem_wdata   = {23'b0, (w_sel_b ? b_tag : a_tag)};

    assign w_pop    = mem_rvalid && !w_empty;
    assign w_head_b = r_grant[r_rptr];
    assign a_rvalid = w_pop && !w_head_b;
    assign b_rvalid = w_pop && w_head_b;
    assign a_rdata  = mem_rdata;
    assign a_raddr  = mem_raddr;
    assign a_rtag   = mem_rtag;
    assign b_rdata  = mem_rdata;
    assign b_raddr  = mem_raddr;
    assign b_rtag   = mem_rtag;
    assign err_orphan = r_err_orphan;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_grant <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_grant[r_wptr] <= w_sel_b;
                r_wptr          <= r_wptr + PW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Any cycle B is not asking resets its claim; a B grant also consumes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_starve <= '0;
        else if (!b_request || (w_accept && w_sel_b))
            r_starve <= '0;
        else if (r_starve != SW'(STARVE_LIMIT))
            r_starve <= r_starve + SW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_err_orphan <= 1'b0;
        else if (mem_rvalid && w_empty)
            r_err_orphan <= 1'b1;
    end
endmodule
